// File: rtl/uart_rx_fifo_if.sv
// Byte read port of uart_rx_fifo: the receiver offers the FIFO head, the consumer pops it
// with a valid/ready handshake.
interface uart_rx_fifo_if;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;

    modport master (
        output rdata,
        output rvalid,
        input  rready
    );

    modport slave (
        input  rdata,
        input  rvalid,
        output rready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// power-of-two byte FIFO with framing-error pulse and sticky overrun flag.
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ     = 27000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rx,
    uart_rx_fifo_if.master rd,
    output logic           frame_err,
    output logic           overrun,
    input  logic           overrun_clr
);

    localparam int unsigned Div   = CLK_HZ / BAUD;
    localparam int unsigned CntW  = $clog2(Div);
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

    localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(Div / 2 - 1);

    // ------------------------------------------------------------------
    // Input synchronizer and falling-edge detect
    // ------------------------------------------------------------------
    logic rx_meta_q, rxs_q, rxs_prev_q;
    logic rx_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    assign rx_fall = rxs_prev_q & ~rxs_q;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            frame_err_q, frame_err_d;
    logic            bit_tick;
    logic            push;
`ifdef UART_RX_PARITY_EN
    logic            par_err_q, par_err_d;
`endif

    assign bit_tick = (cnt_q == CntLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rx_fall) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A high line at mid start bit is a glitch, not a frame.
                    state_d = rxs_q ? StIdle : StData;
                end
            end
            StData: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        push        = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (bit_tick) begin
                    par_err_d   = ^{shift_q, rxs_q};
                    frame_err_d = par_err_d;
                end
            end
            StStop: begin
                // A parity failure has already pulsed; the stop bit is only consumed.
                if (bit_tick && !par_err_q) begin
                    push        = rxs_q;
                    frame_err_d = ~rxs_q;
                end
            end
`else
            StStop: begin
                if (bit_tick) begin
                    push        = rxs_q;
                    frame_err_d = ~rxs_q;
                end
            end
`endif
            default: ;
        endcase
    end

    assign frame_err = frame_err_q;

    // ------------------------------------------------------------------
    // Byte FIFO; pointers carry an extra wrap bit to tell full from empty
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [AddrW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic             overrun_q, overrun_d;
    logic             empty, full, pop, wr_en, ovr_set;

    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                  (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
        pop     = !empty && rd.rready;
        // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
        wr_en   = push && (!full || pop);
        ovr_set = push && full && !pop;

        wptr_d    = wr_en ? wptr_q + (AddrW+1)'(1) : wptr_q;
        rptr_d    = pop   ? rptr_q + (AddrW+1)'(1) : rptr_q;
        overrun_d = ovr_set | (overrun_q & ~overrun_clr);

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wptr_q[AddrW-1:0]] = shift_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            overrun_q <= overrun_d;
            mem_q     <= mem_d;
        end
    end

    assign rd.rdata  = mem_q[rptr_q[AddrW-1:0]];
    assign rd.rvalid = !empty;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo (8N1, DIV=16) against a queue-based byte model.
module tb_uart_rx_fifo;

    localparam int unsigned ClkHz = 16;
    localparam int unsigned Baud  = 1;
    localparam int unsigned Depth = 16;
    localparam int Div      = ClkHz / Baud;
    localparam int FrameLen = 10 * Div;
    // Cycles from driving the start bit low to the stop-sample edge.
    localparam int StopEdge = 3 + Div / 2 + 9 * Div;

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic rx          = 1'b1;
    logic overrun_clr = 1'b0;
    logic frame_err;
    logic overrun;

    uart_rx_fifo_if u_if ();

    uart_rx_fifo #(
        .CLK_HZ    (ClkHz),
        .BAUD      (Baud),
        .FIFO_DEPTH(Depth)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rd         (u_if.master),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_err  = 0;
    int         fe_cnt = 0;
    logic [7:0] exp_q [$];
    logic       exp_ovr = 1'b0;

    always @(negedge clk) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        rx          = 1'b1;
        u_if.rready = 1'b0;
        overrun_clr = 1'b0;
        #1;
        check_val("rst_rvalid", 32'(u_if.rvalid), 32'd0);
        check_val("rst_rdata", 32'(u_if.rdata), 32'd0);
        check_val("rst_frame_err", 32'(frame_err), 32'd0);
        check_val("rst_overrun", 32'(overrun), 32'd0);
        exp_q.delete();
        exp_ovr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic idle_line(input logic lvl, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rx = lvl;
        end
    endtask

    // Drives one frame; the model is updated at the stop-sample edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_stop,
                              input int abort_at);
        logic [9:0] bits;
        logic       popping;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < FrameLen; i++) begin
            @(negedge clk);
            if (i == abort_at) return;
            if (i == StopEdge - 1) begin
                check_val("pre_stop_ferr", 32'(frame_err), 32'd0);
                check_val("pre_stop_rvalid", 32'(u_if.rvalid), 32'(exp_q.size() != 0));
                if (pop_at_stop && exp_q.size() != 0) begin
                    check_val("pre_stop_rdata", 32'(u_if.rdata), 32'(exp_q[0]));
                    u_if.rready = 1'b1;
                end
            end
            if (i == StopEdge) begin
                u_if.rready = 1'b0;
                popping = pop_at_stop && exp_q.size() != 0;
                if (popping) void'(exp_q.pop_front());
                if (stop) begin
                    if (exp_q.size() >= Depth) exp_ovr = 1'b1;
                    else exp_q.push_back(b);
                end
                check_val("stop_ferr", 32'(frame_err), 32'(!stop));
                check_val("stop_rvalid", 32'(u_if.rvalid), 32'(exp_q.size() != 0));
                check_val("stop_overrun", 32'(overrun), 32'(exp_ovr));
                if (exp_q.size() != 0) check_val("stop_head", 32'(u_if.rdata), 32'(exp_q[0]));
            end
            if (i == StopEdge + 1) check_val("ferr_one_cycle", 32'(frame_err), 32'd0);
            rx = bits[i / Div];
        end
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_val("drain_rvalid", 32'(u_if.rvalid), 32'd1);
            check_val("drain_rdata", 32'(u_if.rdata), 32'(exp_q[0]));
            u_if.rready = 1'b1;
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        u_if.rready = 1'b0;
        check_val("drain_rvalid_after", 32'(u_if.rvalid), 32'(exp_q.size() != 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0;
        logic [7:0] rb;
        u_if.rready = 1'b0;
        do_reset();

        // Single frame, exact arrival time checked inside send_frame
        send_frame(8'h55, 1'b1, 1'b0, -1);
        idle_line(1'b1, 4);
        drain(1);

        // Glitch shorter than half a bit
        fe0 = fe_cnt;
        idle_line(1'b0, 3);
        idle_line(1'b1, 3 * Div);
        check_val("glitch_rvalid", 32'(u_if.rvalid), 32'd0);
        check_val("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);

        // Bad stop bit, line then held low: one pulse only, no byte
        fe0 = fe_cnt;
        send_frame(8'hA3, 1'b0, 1'b0, -1);
        idle_line(1'b0, 3 * Div);
        idle_line(1'b1, 4);
        check_val("bad_stop_pulses", 32'(fe_cnt - fe0), 32'd1);
        check_val("bad_stop_rvalid", 32'(u_if.rvalid), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        idle_line(1'b1, 4);
        drain(1);

        // Overflow by one, drain in order, clear sticky flag
        for (int k = 0; k < 17; k++) begin
            send_frame(8'(k), 1'b1, 1'b0, -1);
            idle_line(1'b1, 2);
        end
        check_val("overrun_set", 32'(overrun), 32'd1);
        drain(16);
        @(negedge clk);
        overrun_clr = 1'b1;
        exp_ovr = 1'b0;
        @(negedge clk);
        overrun_clr = 1'b0;
        check_val("overrun_clr", 32'(overrun), 32'd0);

        // Full FIFO with a pop in the completion cycle keeps 16 entries
        for (int k = 0; k < 16; k++) begin
            send_frame(8'($urandom), 1'b1, 1'b0, -1);
            idle_line(1'b1, 2);
        end
        send_frame(8'h7E, 1'b1, 1'b1, -1);
        idle_line(1'b1, 2);
        check_val("full_pop_overrun", 32'(overrun), 32'd0);
        check_val("full_pop_depth", 32'(exp_q.size()), 32'(Depth));
        drain(16);

        // Reset in the middle of data bit 4 with two bytes queued
        send_frame(8'h11, 1'b1, 1'b0, -1);
        idle_line(1'b1, 2);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        idle_line(1'b1, 2);
        send_frame(8'h99, 1'b1, 1'b0, 5 * Div + Div / 2);
        do_reset();
        send_frame(8'h42, 1'b1, 1'b0, -1);
        idle_line(1'b1, 4);
        drain(1);

        // Random traffic with occasional bad stops and pops
        for (int k = 0; k < 24; k++) begin
            rb = 8'($urandom);
            send_frame(rb, $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0, -1);
            idle_line(1'b1, $urandom_range(2, 6));
            if ($urandom_range(0, 2) == 0) drain($urandom_range(0, exp_q.size()));
        end
        drain(exp_q.size());

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
